// File: rtl/aes_ks_pkg.sv
// ---------------------------------------------------------------------------
// aes_ks_pkg : shared types and constants for the AES-256 key-schedule control
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package aes_ks_pkg;
  localparam int NUM_RK       = 15;
  localparam int AES256_KEY_W = 256;
  localparam int RK_W         = 128;

  typedef logic [RK_W-1:0] rk_t;

  typedef logic [2:0] ks_state_e;
  localparam ks_state_e S_IDLE  = 3'd0;
  localparam ks_state_e S_ISSUE = 3'd1;
  localparam ks_state_e S_WAIT  = 3'd2;
  localparam ks_state_e S_STORE = 3'd3;
  localparam ks_state_e S_DONE  = 3'd4;
  localparam ks_state_e S_ERR   = 3'd5;
endpackage

`default_nettype wire

// File: rtl/aes_rk_store.sv
// ---------------------------------------------------------------------------
// aes_rk_store : 15x128 round-key file, valid mask, registered read w/ bypass
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_rk_store
  import aes_ks_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       we_i,
  input  logic [3:0] waddr_i,
  input  rk_t        wdata_i,
  input  logic       req_i,
  input  logic [3:0] idx_i,
  output logic       valid_o,
  output rk_t        rdata_o
);

  rk_t               r_mem [NUM_RK];
  logic [NUM_RK-1:0] r_mask;
  logic              r_valid;
  rk_t               r_rdata;

  logic              w_in_range;
  logic [3:0]        w_ridx;
  logic [15:0]       w_mask_ext;
  logic              w_byp;
  logic              w_hit;

  assign w_in_range = idx_i < 4'(NUM_RK);
  assign w_ridx     = w_in_range ? idx_i : 4'd0;
  assign w_mask_ext = {{(16-NUM_RK){1'b0}}, r_mask};
  assign w_byp      = we_i && (waddr_i == idx_i);
  // A start clears the mask this cycle, so stale entries must not be served.
  assign w_hit      = req_i && w_in_range && !clr_i && (w_mask_ext[idx_i] || w_byp);

  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_mask  <= '0;
      r_valid <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (clr_i) r_mask <= '0;
      else if (we_i) r_mask[waddr_i] <= 1'b1;
      r_valid <= w_hit;
      if (w_hit) r_rdata <= w_byp ? wdata_i : r_mem[w_ridx];
    end
  end

  assign valid_o = r_valid;
  assign rdata_o = r_rdata;

endmodule

`default_nettype wire

// File: rtl/aes_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// aes_key_sched_ctrl : AES-256 expander sequencer and round-key store
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_key_sched_ctrl
  import aes_ks_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [AES256_KEY_W-1:0] key_i,
  output logic [AES256_KEY_W-1:0] exp_key_o,
  output logic                    exp_en_o,
  output logic [3:0]              exp_round_o,
  input  logic                    exp_ready_i,
  input  logic [RK_W-1:0]         exp_rk_i,
  input  logic                    rk_req_i,
  input  logic [3:0]              rk_idx_i,
  output logic                    rk_valid_o,
  output logic [RK_W-1:0]         rk_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  ks_state_e               r_state;
  logic [AES256_KEY_W-1:0] r_key;
  logic [3:0]              r_rc;
  logic [TO_W-1:0]         r_to;
  rk_t                     r_rk_cap;
  logic                    r_err;
  logic                    r_err_bad;

  logic                    w_idle_like;
  logic                    w_start_ok;
  logic                    w_bad_idx;
  logic                    w_we;

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
  assign w_start_ok  = start_i && w_idle_like;
  assign w_bad_idx   = rk_req_i && (rk_idx_i > 4'(NUM_RK-1));
  assign w_we        = (r_state == S_STORE);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_key     <= '0;
      r_rc      <= '0;
      r_to      <= '0;
      r_rk_cap  <= '0;
      r_err     <= 1'b0;
      r_err_bad <= 1'b0;
    end else begin
      r_err_bad <= w_bad_idx;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            r_key   <= key_i;
            r_err   <= 1'b0;
            r_rc    <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_to    <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (exp_ready_i) begin
            r_rk_cap <= exp_rk_i;
            r_state  <= S_STORE;
          end else if (r_to == TO_W'(TIMEOUT-1)) begin
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        S_STORE: begin
          if (r_rc == 4'(NUM_RK-1)) begin
            r_state <= S_DONE;
          end else begin
            r_rc    <= r_rc + 1'b1;
            r_state <= S_ISSUE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  aes_rk_store u_store (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .clr_i   (w_start_ok),
    .we_i    (w_we),
    .waddr_i (r_rc),
    .wdata_i (r_rk_cap),
    .req_i   (rk_req_i),
    .idx_i   (rk_idx_i),
    .valid_o (rk_valid_o),
    .rdata_o (rk_o)
  );

  // ISSUE keeps exp_en_o low for one cycle so the expander sees a reset gap.
  assign exp_en_o    = (r_state == S_WAIT);
  assign exp_round_o = r_rc;
  assign exp_key_o   = r_key;
  assign busy_o      = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_STORE);
  assign done_o      = (r_state == S_DONE);
  assign err_o       = r_err || r_err_bad;

endmodule

`default_nettype wire
